// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU op codes, arbiter state type and op decode helper
package alu_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  // Function field (op[2:0]); op[3] selects SUB for ADD and SRA for SRL
  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SLL  = 3'b001;
  localparam logic [2:0] FN_SLT  = 3'b010;
  localparam logic [2:0] FN_SLTU = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_SRL  = 3'b101;
  localparam logic [2:0] FN_OR   = 3'b110;
  localparam logic [2:0] FN_AND  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  function automatic logic [2:0] op_fn(input logic [3:0] op);
    return op[2:0];
  endfunction

  function automatic logic op_alt(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_b_neg;

  assign w_shamt = i_b[4:0];
  assign w_b_neg = ~i_b + {{(XLEN-1){1'b0}}, 1'b1};

  // Decode the function field and compute the result
  always_comb begin
    o_result = '0;
    case (op_fn(i_op))
      FN_ADD:  o_result = op_alt(i_op) ? (i_a + w_b_neg) : (i_a + i_b);
      FN_SLL:  o_result = i_a << w_shamt;
      FN_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      FN_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      FN_XOR:  o_result = i_a ^ i_b;
      FN_SRL:  o_result = op_alt(i_op) ? $unsigned($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
      FN_OR:   o_result = i_a | i_b;
      FN_AND:  o_result = i_a & i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one ALU
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic DEFAULT_PRIO = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [3:0]      i_req0_op,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [3:0]      i_req1_op,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_busy
);

  arb_state_t      r_state;
  logic            r_owner;
  logic            r_last;
  logic [XLEN-1:0] r_data;

  logic            w_drain;
  logic            w_issue_ok;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_accept;
  logic [3:0]      w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_result;

  // The owner consuming its result frees the ALU in the same cycle; the
  // reset term keeps both readies low while the block is held in reset.
  assign w_drain    = (r_state == ST_HOLD) && (r_owner ? i_rsp1_ready : i_rsp0_ready);
  assign w_issue_ok = i_rst_n && ((r_state == ST_IDLE) || w_drain);

  // On contention the requester not granted last time wins
  assign w_grant0 = w_issue_ok && i_req0_valid && (!i_req1_valid || r_last);
  assign w_grant1 = w_issue_ok && i_req1_valid && (!i_req0_valid || !r_last);
  assign w_accept = w_grant0 || w_grant1;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  assign w_op = w_grant1 ? i_req1_op : i_req0_op;
  assign w_a  = w_grant1 ? i_req1_a  : i_req0_a;
  assign w_b  = w_grant1 ? i_req1_b  : i_req0_b;

  alu u_alu (
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_result)
  );

  // Issue/hold/drain state machine with the shared result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= ~DEFAULT_PRIO;
      r_data  <= '0;
    end else if (w_accept) begin
      r_state <= ST_HOLD;
      r_owner <= w_grant1;
      r_last  <= w_grant1;
      r_data  <= w_result;
    end else if (w_drain) begin
      r_state <= ST_IDLE;
    end
  end

  assign o_busy       = (r_state == ST_HOLD);
  assign o_rsp0_valid = (r_state == ST_HOLD) && !r_owner;
  assign o_rsp1_valid = (r_state == ST_HOLD) &&  r_owner;
  assign o_rsp_data   = r_data;

endmodule
